// File: rtl/my_image_frame_tx_ctrl.sv
// Frame transmit controller: gates a pixel stream into fixed-length frames and feeds
// an AXI-Stream master through a 2-entry skid FIFO that carries the last-beat flag.
module my_image_frame_tx_ctrl #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int C_LEN_WIDTH          = 24
) (
    input  logic                            M_AXIS_ACLK,
    input  logic                            M_AXIS_ARESETN,
    input  logic                            start,
    input  logic [C_LEN_WIDTH-1:0]          frame_len,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0] px_data,
    input  logic                            px_valid,
    output logic                            px_ready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] data_out,
    output logic                            valid_out,
    output logic                            last_out,
    input  logic                            ready_in,
    output logic                            busy,
    output logic                            done,
    output logic [15:0]                     frames_sent
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic [C_LEN_WIDTH-1:0] LEN_ONE = {{(C_LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t                           state_q, state_d;
    logic [C_LEN_WIDTH-1:0]           len_q, len_d;
    logic [C_LEN_WIDTH-1:0]           inCnt_q, inCnt_d;
    logic [C_LEN_WIDTH-1:0]           inCntNext;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]  fifoData_q [2];
    logic [1:0]                       fifoLast_q;
    logic                             wrPtr_q;
    logic                             rdPtr_q;
    logic [1:0]                       count_q;
    logic                             done_q;
    logic [15:0]                      frames_q;

    logic fifoFull;
    logic fifoEmpty;
    logic headLast;
    logic push;
    logic pop;
    logic pushLast;
    logic lastXfer;

    assign fifoFull  = (count_q == 2'd2);
    assign fifoEmpty = (count_q == 2'd0);
    assign headLast  = fifoLast_q[rdPtr_q];

    // px_ready depends only on registered state, never on ready_in.
    assign px_ready  = (state_q == RUN) && !fifoFull;
    assign push      = px_valid && px_ready;
    assign pop       = valid_out && ready_in;

    // inCnt_q never exceeds len_q-1 while in RUN, so the increment cannot wrap.
    assign inCntNext = inCnt_q + LEN_ONE;
    assign pushLast  = (inCntNext == len_q);
    assign lastXfer  = pop && headLast && (state_q == DRAIN);

    assign valid_out   = !fifoEmpty;
    assign data_out    = fifoEmpty ? '0 : fifoData_q[rdPtr_q];
    assign last_out    = !fifoEmpty && headLast;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign frames_sent = frames_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        inCnt_d = inCnt_q;
        case (state_q)
            IDLE: begin
                if (start && (frame_len != '0)) begin
                    state_d = RUN;
                    len_d   = frame_len;
                    inCnt_d = '0;
                end
            end
            RUN: begin
                if (push) begin
                    inCnt_d = inCntNext;
                    if (pushLast) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (lastXfer) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            state_q       <= IDLE;
            len_q         <= '0;
            inCnt_q       <= '0;
            fifoData_q[0] <= '0;
            fifoData_q[1] <= '0;
            fifoLast_q    <= '0;
            wrPtr_q       <= 1'b0;
            rdPtr_q       <= 1'b0;
            count_q       <= 2'd0;
            done_q        <= 1'b0;
            frames_q      <= 16'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            inCnt_q <= inCnt_d;
            if (push) begin
                fifoData_q[wrPtr_q] <= px_data;
                fifoLast_q[wrPtr_q] <= pushLast;
                wrPtr_q             <= ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
            done_q <= lastXfer;
            if (lastXfer) begin
                frames_q <= frames_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_my_image_frame_tx_ctrl.sv
// Scoreboard bench for my_image_frame_tx_ctrl: accepted pixels queue expected beats,
// a negedge monitor pops and compares every transferred beat plus done/frames_sent.
module tb_my_image_frame_tx_ctrl;

    localparam int DW = 32;
    localparam int LW = 24;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [LW-1:0] frameLen;
    logic [DW-1:0] pxData;
    logic          pxValid;
    logic          pxReady;
    logic [DW-1:0] dataOut;
    logic          validOut;
    logic          lastOut;
    logic          readyIn;
    logic          busy;
    logic          done;
    logic [15:0]   framesSent;

    always #5 clk = ~clk;

    my_image_frame_tx_ctrl #(
        .C_M_AXIS_TDATA_WIDTH(DW),
        .C_LEN_WIDTH         (LW)
    ) dut (
        .M_AXIS_ACLK   (clk),
        .M_AXIS_ARESETN(resetn),
        .start         (start),
        .frame_len     (frameLen),
        .px_data       (pxData),
        .px_valid      (pxValid),
        .px_ready      (pxReady),
        .data_out      (dataOut),
        .valid_out     (validOut),
        .last_out      (lastOut),
        .ready_in      (readyIn),
        .busy          (busy),
        .done          (done),
        .frames_sent   (framesSent)
    );

    int            errors = 0;
    int            checks = 0;
    beat_t         sbq[$];
    beat_t         expBeat;
    beat_t         gotBeat;
    int            curLen = 0;
    int            beatIdx = 0;
    bit            monEn = 1'b0;
    bit            doneExp = 1'b0;
    logic [15:0]   fsExp = 16'd0;
    int            readyMode = 0;
    bit            prevStall = 1'b0;
    logic [DW-1:0] prevData;
    int            cycle = 0;
    int            xferCnt = 0;
    int            firstXfer = 0;
    int            lastXferCyc = 0;
    bit            sawFull = 1'b0;
    bit            accNow = 1'b0;
    int            occ;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cycle++;

    // Pixel source and ready_in pattern update just after each edge.
    always @(posedge clk) begin
        #1;
        if (accNow) pxData = pxData + 32'h0101_0101;
        if (readyMode == 1) readyIn = ~readyIn;
    end

    // Monitor and scoreboard: outputs are compared before the next edge consumes them.
    always @(negedge clk) begin
        if (!monEn) begin
            accNow = 1'b0;
        end else begin
            occ = sbq.size();
            checkOutput("done", {63'd0, done}, {63'd0, doneExp});
            if (doneExp) checkOutput("frames_sent", {48'd0, framesSent}, {48'd0, fsExp});
            doneExp = 1'b0;
            checkOutput("valid_out", {63'd0, validOut}, {63'd0, occ != 0});
            if (prevStall) checkOutput("stall_hold", {32'd0, dataOut}, {32'd0, prevData});
            if (occ == 2 && busy) begin
                checkOutput("px_ready_full", {63'd0, pxReady}, 64'd0);
                sawFull = 1'b1;
            end
            prevStall = validOut && !readyIn;
            prevData  = dataOut;
            if (validOut && readyIn) begin
                if (occ == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL extra_beat: got data %0h with no expected beat", dataOut);
                end else begin
                    gotBeat = sbq.pop_front();
                    checkOutput("data_out", {32'd0, dataOut}, {32'd0, gotBeat.data});
                    checkOutput("last_out", {63'd0, lastOut}, {63'd0, gotBeat.last});
                    xferCnt++;
                    if (xferCnt == 1) firstXfer = cycle;
                    lastXferCyc = cycle;
                    if (gotBeat.last) begin
                        doneExp = 1'b1;
                        fsExp   = fsExp + 16'd1;
                    end
                end
            end
            accNow = pxValid && pxReady;
            if (accNow) begin
                beatIdx++;
                expBeat.data = pxData;
                expBeat.last = (beatIdx == curLen);
                sbq.push_back(expBeat);
            end
        end
    end

    task automatic applyStimulus(input int len, input bit expectAccept);
        @(posedge clk);
        #1;
        start    = 1'b1;
        frameLen = len[LW-1:0];
        if (expectAccept) begin
            curLen  = len;
            beatIdx = 0;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string name);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {63'd0, done}, 64'd1);
    endtask

    task automatic doReset();
        monEn   = 1'b0;
        pxValid = 1'b0;
        start   = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid_out", {63'd0, validOut}, 64'd0);
        checkOutput("rst_last_out", {63'd0, lastOut}, 64'd0);
        checkOutput("rst_px_ready", {63'd0, pxReady}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_done", {63'd0, done}, 64'd0);
        checkOutput("rst_data_out", {32'd0, dataOut}, 64'd0);
        checkOutput("rst_frames_sent", {48'd0, framesSent}, 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        sbq.delete();
        doneExp   = 1'b0;
        fsExp     = 16'd0;
        prevStall = 1'b0;
        beatIdx   = 0;
        accNow    = 1'b0;
        monEn     = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        resetn    = 1'b0;
        start     = 1'b0;
        frameLen  = '0;
        pxData    = 32'hA000_0000;
        pxValid   = 1'b0;
        readyIn   = 1'b1;
        readyMode = 0;
        doReset();

        $display("[TB] single frame, length 4");
        pxValid = 1'b1;
        xferCnt = 0;
        applyStimulus(4, 1'b1);
        waitDone(50, "len4_done");
        checkOutput("len4_beats", xferCnt, 4);
        checkOutput("len4_span", lastXferCyc - firstXfer, 3);

        $display("[TB] zero length start");
        applyStimulus(0, 1'b0);
        @(negedge clk);
        checkOutput("len0_busy", {63'd0, busy}, 64'd0);
        checkOutput("len0_px_ready", {63'd0, pxReady}, 64'd0);

        $display("[TB] single beat frame");
        xferCnt = 0;
        applyStimulus(1, 1'b1);
        waitDone(50, "len1_done");
        checkOutput("len1_beats", xferCnt, 1);

        $display("[TB] start ignored while running");
        xferCnt = 0;
        applyStimulus(5, 1'b1);
        repeat (2) @(posedge clk);
        applyStimulus(9, 1'b0);
        waitDone(100, "ign_done");
        repeat (5) @(negedge clk);
        checkOutput("ign_beats", xferCnt, 5);
        checkOutput("ign_busy", {63'd0, busy}, 64'd0);

        $display("[TB] backpressure, length 8");
        readyMode = 1;
        sawFull   = 1'b0;
        xferCnt   = 0;
        applyStimulus(8, 1'b1);
        waitDone(200, "bp_done");
        readyMode = 0;
        readyIn   = 1'b1;
        checkOutput("bp_beats", xferCnt, 8);
        checkOutput("bp_saw_full", {63'd0, sawFull}, 64'd1);

        $display("[TB] back-to-back frames of length 3");
        xferCnt = 0;
        applyStimulus(3, 1'b1);
        waitDone(50, "b2b_done1");
        start    = 1'b1;
        frameLen = 24'd3;
        curLen   = 3;
        beatIdx  = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(50, "b2b_done2");
        checkOutput("b2b_beats", xferCnt, 6);

        $display("[TB] reset in the middle of a frame");
        xferCnt = 0;
        applyStimulus(10, 1'b1);
        n = 0;
        while (xferCnt < 5 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("mid_reached5", {63'd0, xferCnt >= 5}, 64'd1);
        doReset();
        pxValid = 1'b1;
        xferCnt = 0;
        applyStimulus(2, 1'b1);
        waitDone(50, "post_rst_done");
        checkOutput("post_rst_beats", xferCnt, 2);
        @(negedge clk);
        #1;
        checkOutput("final_frames", {48'd0, framesSent}, 64'd1);
        checkOutput("sb_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
